// File: rtl/conv_pkg.sv
// Shared widths and the sequencer state encoding for the convolution PE
// front end.
package conv_pkg;

  localparam int DATA_W = 30;
  localparam int WGT_W  = 18;
  localparam int ACC_W  = 48;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    RUN,
    FLUSH,
    DONE
  } state_t;

endpackage

// File: rtl/conv_valid_pipe.sv
// Window tag and frame-last shift register.
// It mirrors the PE pipeline depth so that flags line up with the PE result.
module conv_valid_pipe #(
  parameter int STAGES = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_tag,
  input  logic i_last,
  output logic o_tag,
  output logic o_last
);

  logic [STAGES-1:0] tag_sr;
  logic [STAGES-1:0] last_sr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tag_sr  <= '0;
      last_sr <= '0;
    end else begin
      tag_sr[0]  <= i_tag;
      last_sr[0] <= i_last;
      for (int i = 1; i < STAGES; i++) begin
        tag_sr[i]  <= tag_sr[i-1];
        last_sr[i] <= last_sr[i-1];
      end
    end
  end

  assign o_tag  = tag_sr[STAGES-1];
  assign o_last = last_sr[STAGES-1];

endmodule

// File: rtl/conv_pe_sequencer.sv
// Drives one KxK DSP-cascade convolution PE. It loads the weights, streams a
// raster frame gap-free, and emits only the PE results that cover a full window.
module conv_pe_sequencer
  import conv_pkg::*;
#(
  parameter int KERNEL_SIZE = 2,
  parameter int IMG_W       = 8,
  parameter int IMG_H       = 8,
  parameter int PE_LATENCY  = 4
) (
  input  logic                                     i_clk,
  input  logic                                     i_rst_n,
  input  logic                                     i_start,
  input  logic [WGT_W-1:0]                         i_wgt,
  input  logic                                     i_wgt_valid,
  input  logic [DATA_W-1:0]                        s_pix_data,
  input  logic                                     s_pix_valid,
  output logic                                     s_pix_ready,
  output logic [DATA_W-1:0]                        o_pe_datafm,
  output logic [KERNEL_SIZE*KERNEL_SIZE*WGT_W-1:0] o_pe_weight,
  input  logic [ACC_W-1:0]                         i_pe_p,
  output logic [ACC_W-1:0]                         m_data,
  output logic                                     m_valid,
  output logic                                     m_last,
  output logic                                     o_busy,
  output logic                                     o_done,
  output logic                                     o_err
);

  localparam int NW     = KERNEL_SIZE * KERNEL_SIZE;
  localparam int WCNT_W = (NW > 1) ? $clog2(NW) : 1;
  localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int FCNT_W = (PE_LATENCY > 1) ? $clog2(PE_LATENCY) : 1;

  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(NW - 1);
  localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]  ROW_MAX  = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0]  COL_WIN  = COL_W'(KERNEL_SIZE - 1);
  localparam logic [ROW_W-1:0]  ROW_WIN  = ROW_W'(KERNEL_SIZE - 1);
  localparam logic [FCNT_W-1:0] FCNT_MAX = FCNT_W'(PE_LATENCY - 1);

  state_t                   state;
  state_t                   state_nxt;
  logic [WCNT_W-1:0]        wgt_cnt;
  logic [COL_W-1:0]         col;
  logic [ROW_W-1:0]         row;
  logic [FCNT_W-1:0]        flush_cnt;
  logic [NW*WGT_W-1:0]      wgt_q;
  logic signed [DATA_W-1:0] datafm_p0;
  logic                     tag_p0;
  logic                     last_p0;
  logic                     tag_tail;
  logic                     last_tail;
  logic signed [ACC_W-1:0]  m_data_p1;
  logic                     m_valid_p1;
  logic                     m_last_p1;
  logic                     err_q;
  logic                     pix_fire;
  logic                     underrun;
  logic                     last_pix;
  logic                     win_tag;
  logic                     started;

  assign last_pix = (col == COL_MAX) && (row == ROW_MAX);
  assign win_tag  = (col >= COL_WIN) && (row >= ROW_WIN);
  // Pixel (0,0) is the only point before the frame wraps where both counters are zero.
  assign started  = (col != '0) || (row != '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pix_fire  = 1'b0;
    underrun  = 1'b0;
    case (state)
      IDLE:   if (i_start) state_nxt = LOAD_W;
      LOAD_W: if (i_wgt_valid && (wgt_cnt == WCNT_MAX)) state_nxt = RUN;
      RUN: begin
        if (s_pix_valid) begin
          pix_fire = 1'b1;
          if (last_pix) state_nxt = FLUSH;
        end else if (started) begin
          underrun  = 1'b1;
          state_nxt = FLUSH;
        end
      end
      FLUSH:  if (flush_cnt == FCNT_MAX) state_nxt = DONE;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: weight file, raster counters and the pixel register feeding the PE
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wgt_cnt   <= '0;
      col       <= '0;
      row       <= '0;
      flush_cnt <= '0;
      wgt_q     <= '0;
      datafm_p0 <= '0;
      tag_p0    <= 1'b0;
      last_p0   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      datafm_p0 <= '0;
      tag_p0    <= 1'b0;
      last_p0   <= 1'b0;
      flush_cnt <= (state == FLUSH) ? flush_cnt + 1'b1 : '0;
      if ((state == IDLE) && i_start) begin
        wgt_cnt <= '0;
        col     <= '0;
        row     <= '0;
        err_q   <= 1'b0;
      end
      if ((state == LOAD_W) && i_wgt_valid) begin
        wgt_cnt <= wgt_cnt + 1'b1;
        for (int n = 0; n < NW; n++)
          if (wgt_cnt == WCNT_W'(n)) wgt_q[n*WGT_W +: WGT_W] <= i_wgt;
      end
      if (pix_fire) begin
        datafm_p0 <= s_pix_data;
        tag_p0    <= win_tag;
        last_p0   <= last_pix;
        if (col == COL_MAX) begin
          col <= '0;
          row <= (row == ROW_MAX) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (underrun) err_q <= 1'b1;
    end
  end

  conv_valid_pipe #(
    .STAGES (PE_LATENCY)
  ) u_valid_pipe (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_tag  (tag_p0),
    .i_last (last_p0),
    .o_tag  (tag_tail),
    .o_last (last_tail)
  );

  // Stage p1: capture the PE sum when a tagged window reaches the pipe tail
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_data_p1  <= '0;
      m_valid_p1 <= 1'b0;
      m_last_p1  <= 1'b0;
    end else begin
      m_valid_p1 <= tag_tail && !err_q;
      m_last_p1  <= tag_tail && last_tail && !err_q;
      if (tag_tail && !err_q) m_data_p1 <= i_pe_p;
    end
  end

  assign o_pe_datafm = datafm_p0;
  assign o_pe_weight = wgt_q;
  assign m_data      = m_data_p1;
  assign m_valid     = m_valid_p1;
  assign m_last      = m_last_p1;
  assign s_pix_ready = (state == RUN);
  assign o_busy      = (state != IDLE);
  assign o_done      = (state == DONE);
  assign o_err       = err_q;

endmodule
